oven_cook_sequencer: RTL and testbench
======================================

Name: oven_cook_sequencer

Overview:
- Multi-step cook program scheduler sitting above the oven temperature/timer datapath.
- Holds a small table of steps, each a setpoint temperature plus a cook time. On start it drives the oven setpoint, waits for oven ready, counts the step time down on the one-second tick, then advances to the next step.
- After the last step it raises a timed done alarm. The display logic reads its step index and remaining time.

Parameters:
- MAX_STEPS, 4, number of step table entries (index width = 2).
- MIN_TEMP, 150, lowest legal setpoint in degrees F; lower writes are clamped up to this.
- MAX_TEMP, 500, highest legal setpoint; higher writes are clamped down to this.
- MAX_TIME, 3600, largest step time in seconds; larger writes are clamped to this.
- ALARM_SECS, 10, seconds the alarm output stays high unless acknowledged.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sec_tick  in  1  single-cycle pulse once per second, synchronous to clk.
- prog_we  in  1  step table write strobe.
- prog_addr  in  2  step index to write.
- prog_temp  in  9  setpoint for the step.
- prog_time  in  12  cook seconds for the step.
- num_steps  in  3  steps to run, 1..MAX_STEPS; sampled at start.
- start  in  1  begin program (level, edge-detected internally).
- abort  in  1  stop immediately.
- alarm_ack  in  1  clear the alarm.
- oven_ready  in  1  oven at setpoint (MAINTAIN state).
- heat_en  out  1  oven on request.
- setpoint  out  9  active step temperature.
- remaining  out  12  seconds left in the current step.
- step_idx  out  2  current step.
- busy  out  1  program running.
- step_done  out  1  one-cycle pulse at each step completion.
- alarm  out  1  program-complete alarm.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - heat_en = 0, setpoint = 0, remaining = 0, step_idx = 0, busy = 0, step_done = 0, alarm = 0.
  - Table entries = {MIN_TEMP, 0}.
- Table writes:
  - Accepted only in IDLE or ALARM; ignored while busy.
  - Temperature and time are clamped to their limits at write time.
- start acts on its rising edge only. A start seen while busy is ignored.
- num_steps is latched at start: 0 is treated as 1, values above MAX_STEPS as MAX_STEPS.
- FSM states are IDLE, LOAD, HEAT, COOK, ADVANCE, ALARM.
- IDLE: on start edge go to LOAD with step_idx = 0, busy = 1.
- LOAD (1 cycle):
  - setpoint and remaining are loaded from the table[step_idx]; heat_en = 1.
  - Go to HEAT.
- HEAT:
  - Hold remaining; wait for oven_ready = 1, then go to COOK.
  - sec_tick is ignored in this state.
- COOK:
  - On sec_tick, remaining decrements by 1; the counter saturates at 0 and never wraps.
  - If remaining = 0 on entry, or reaches 0 on a tick, go to ADVANCE on the next cycle. A zero-time step completes as soon as the oven is ready.
  - If oven_ready drops, return to HEAT with remaining frozen. The countdown resumes from that value on re-entry.
- ADVANCE (1 cycle):
  - Pulse step_done.
  - If step_idx + 1 < latched count: increment step_idx and go to LOAD.
  - Otherwise: heat_en = 0, busy = 0, alarm = 1, load the alarm counter with ALARM_SECS, go to ALARM.
- ALARM:
  - Decrement the alarm counter on sec_tick.
  - alarm clears and the FSM returns to IDLE when the counter reaches 0 or on alarm_ack, whichever comes first.
  - A start edge in ALARM clears the alarm and goes to LOAD with step_idx = 0, in the same cycle.
- abort:
  - In any state, go to IDLE next cycle: heat_en = 0, busy = 0, alarm = 0, remaining = 0, no step_done pulse.
  - abort has priority over start, sec_tick and oven_ready in the same cycle.
- A sec_tick arriving in the same cycle COOK is entered is not counted.
- Asynchronous reset mid-program returns everything to its reset value, including the table contents.

Decomposition:
- Shared package oven_pkg holds:
  - the FSM state encoding;
  - ROOM_TEMP = 65, DEFAULT_TEMP = 300, MAX_TEMP = 500 constants shared with the oven core;
  - the step entry struct {temp[8:0], time[11:0]}.
- One sub-module, oven_step_table: the MAX_STEPS-entry register file with clamping write port and combinational read.

Test Plan:
- Program 2 steps {350F, 3s} and {400F, 2s}, num_steps = 2, start; assert oven_ready 5 cycles after each LOAD. Expect setpoint 350 then 400, remaining counting 3,2,1,0 then 2,1,0, two step_done pulses, alarm high for 10 ticks, busy low at the end.
- Write prog_temp = 100 and prog_time = 4000. Expect the stored and driven setpoint = 150 and remaining = 3600.
- Drop oven_ready at remaining = 2 in COOK and hold it low for 5 ticks. Expect remaining frozen at 2, state HEAT; countdown resumes from 2 after ready returns.
- Step time = 0. Expect step_done one cycle after COOK entry with no sec_tick needed.
- abort coincident with sec_tick and start mid-COOK. Expect IDLE, heat_en = 0, remaining = 0, no step_done. A prog_we issued while busy leaves the table unchanged.
- Assert rst_n low mid-COOK. Expect all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared oven types and limits: FSM encoding, setpoint/time limits and the step table entry.
// Limits are shared with the oven temperature/timer core.
package oven_pkg;

    localparam int MAX_STEPS = 4;
    localparam int STEP_W    = 2;

    localparam logic [8:0]  ROOM_TEMP    = 9'd65;
    localparam logic [8:0]  DEFAULT_TEMP = 9'd300;
    localparam logic [8:0]  MIN_TEMP     = 9'd150;
    localparam logic [8:0]  MAX_TEMP     = 9'd500;
    localparam logic [11:0] MAX_TIME     = 12'd3600;
    localparam logic [3:0]  ALARM_SECS   = 4'd10;
    localparam logic [2:0]  STEPS_MAX    = 3'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEAT,
        COOK,
        ADVANCE,
        ALARM
    } state_t;

    typedef struct packed {
        logic [8:0]  temp;
        logic [11:0] cook_time;
    } step_t;

    function automatic logic [8:0] clamp_temp(input logic [8:0] t);
        if (t < MIN_TEMP) return MIN_TEMP;
        if (t > MAX_TEMP) return MAX_TEMP;
        return t;
    endfunction

    function automatic logic [11:0] clamp_time(input logic [11:0] s);
        return (s > MAX_TIME) ? MAX_TIME : s;
    endfunction

endpackage

// File: rtl/oven_step_table.sv
// Step register file: clamping write port (1-cycle), combinational read (0-cycle).
// No backpressure; the write strobe is gated by the owner, writes always land.
module oven_step_table
    import oven_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_vld,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [8:0]        wr_temp,
    input  logic [11:0]       wr_time,
    input  logic [STEP_W-1:0] rd_addr,
    output step_t             rd_dat
);

    step_t tbl_q [MAX_STEPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                tbl_q[i] <= '{temp: MIN_TEMP, cook_time: 12'd0};
            end
        end else if (wr_vld) begin
            tbl_q[wr_addr] <= '{temp: clamp_temp(wr_temp), cook_time: clamp_time(wr_time)};
        end
    end

    assign rd_dat = tbl_q[rd_addr];

endmodule

// File: rtl/oven_cook_sequencer.sv
// Multi-step cook program scheduler: drives oven setpoint, counts step time on sec_tick, raises done alarm.
// All outputs registered (1-cycle); no backpressure, oven_ready gates the countdown.
module oven_cook_sequencer
    import oven_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_tick,
    input  logic        prog_we,
    input  logic [1:0]  prog_addr,
    input  logic [8:0]  prog_temp,
    input  logic [11:0] prog_time,
    input  logic [2:0]  num_steps,
    input  logic        start,
    input  logic        abort,
    input  logic        alarm_ack,
    input  logic        oven_ready,
    output logic        heat_en,
    output logic [8:0]  setpoint,
    output logic [11:0] remaining,
    output logic [1:0]  step_idx,
    output logic        busy,
    output logic        step_done,
    output logic        alarm
);

    state_t      state_q;
    logic        start_q;
    logic [2:0]  count_q;
    logic [1:0]  step_idx_q;
    logic [8:0]  setpoint_q;
    logic [11:0] remaining_q;
    logic [3:0]  alarm_cnt_q;
    logic        heat_en_q;
    logic        busy_q;
    logic        step_done_q;
    logic        alarm_q;

    logic        start_edge;
    logic        tbl_we;
    logic [2:0]  count_d;
    logic [2:0]  next_idx;
    step_t       rd_dat;

    assign start_edge = start & ~start_q;
    assign tbl_we     = prog_we & ((state_q == IDLE) | (state_q == ALARM));
    assign next_idx   = {1'b0, step_idx_q} + 3'd1;

    always_comb begin
        count_d = num_steps;
        if (num_steps == 3'd0) begin
            count_d = 3'd1;
        end else if (num_steps > STEPS_MAX) begin
            count_d = STEPS_MAX;
        end
    end

    oven_step_table u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (tbl_we),
        .wr_addr (prog_addr),
        .wr_temp (prog_temp),
        .wr_time (prog_time),
        .rd_addr (step_idx_q),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            count_q     <= 3'd1;
            step_idx_q  <= 2'd0;
            setpoint_q  <= 9'd0;
            remaining_q <= 12'd0;
            alarm_cnt_q <= 4'd0;
            heat_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            start_q     <= start;
            step_done_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                heat_en_q   <= 1'b0;
                busy_q      <= 1'b0;
                alarm_q     <= 1'b0;
                remaining_q <= 12'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_edge) begin
                            state_q    <= LOAD;
                            step_idx_q <= 2'd0;
                            count_q    <= count_d;
                            busy_q     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        setpoint_q  <= rd_dat.temp;
                        remaining_q <= rd_dat.cook_time;
                        heat_en_q   <= 1'b1;
                        state_q     <= HEAT;
                    end
                    HEAT: begin
                        if (oven_ready) state_q <= COOK;
                    end
                    COOK: begin
                        // Losing ready takes precedence over a tick so the frozen value is exact.
                        if (!oven_ready) begin
                            state_q <= HEAT;
                        end else if (remaining_q == 12'd0) begin
                            state_q     <= ADVANCE;
                            step_done_q <= 1'b1;
                        end else if (sec_tick) begin
                            remaining_q <= remaining_q - 12'd1;
                            if (remaining_q == 12'd1) begin
                                state_q     <= ADVANCE;
                                step_done_q <= 1'b1;
                            end
                        end
                    end
                    ADVANCE: begin
                        if (next_idx < count_q) begin
                            step_idx_q <= next_idx[1:0];
                            state_q    <= LOAD;
                        end else begin
                            heat_en_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= ALARM_SECS;
                            state_q     <= ALARM;
                        end
                    end
                    ALARM: begin
                        if (start_edge) begin
                            alarm_q    <= 1'b0;
                            state_q    <= LOAD;
                            step_idx_q <= 2'd0;
                            count_q    <= count_d;
                            busy_q     <= 1'b1;
                        end else if (alarm_ack) begin
                            alarm_q <= 1'b0;
                            state_q <= IDLE;
                        end else if (sec_tick) begin
                            alarm_cnt_q <= alarm_cnt_q - 4'd1;
                            if (alarm_cnt_q <= 4'd1) begin
                                alarm_q <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign heat_en   = heat_en_q;
    assign setpoint  = setpoint_q;
    assign remaining = remaining_q;
    assign step_idx  = step_idx_q;
    assign busy      = busy_q;
    assign step_done = step_done_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Directed bench for oven_cook_sequencer: clamp vector table plus hand sequences for timing corners.
module tb_oven_cook_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sec_tick = 1'b0;
    logic        prog_we = 1'b0;
    logic [1:0]  prog_addr = 2'd0;
    logic [8:0]  prog_temp = 9'd0;
    logic [11:0] prog_time = 12'd0;
    logic [2:0]  num_steps = 3'd1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        alarm_ack = 1'b0;
    logic        oven_ready = 1'b0;
    logic        heat_en;
    logic [8:0]  setpoint;
    logic [11:0] remaining;
    logic [1:0]  step_idx;
    logic        busy;
    logic        step_done;
    logic        alarm;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    oven_cook_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_tick   (sec_tick),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_temp  (prog_temp),
        .prog_time  (prog_time),
        .num_steps  (num_steps),
        .start      (start),
        .abort      (abort),
        .alarm_ack  (alarm_ack),
        .oven_ready (oven_ready),
        .heat_en    (heat_en),
        .setpoint   (setpoint),
        .remaining  (remaining),
        .step_idx   (step_idx),
        .busy       (busy),
        .step_done  (step_done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [8:0]  temp;
        logic [11:0] tm;
        logic [8:0]  exp_temp;
        logic [11:0] exp_tm;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        do_cycle();
        sec_tick = 1'b0;
    endtask

    task automatic write_step(input logic [1:0] a, input logic [8:0] t, input logic [11:0] s);
        prog_addr = a;
        prog_temp = t;
        prog_time = s;
        prog_we   = 1'b1;
        do_cycle();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        do_cycle();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        do_cycle();
        abort = 1'b0;
    endtask

    initial begin
        int d0;
        vecs[0] = '{temp: 9'd100, tm: 12'd4000, exp_temp: 9'd150, exp_tm: 12'd3600};
        vecs[1] = '{temp: 9'd511, tm: 12'd4095, exp_temp: 9'd500, exp_tm: 12'd3600};
        vecs[2] = '{temp: 9'd149, tm: 12'd3601, exp_temp: 9'd150, exp_tm: 12'd3600};
        vecs[3] = '{temp: 9'd150, tm: 12'd3600, exp_temp: 9'd150, exp_tm: 12'd3600};
        vecs[4] = '{temp: 9'd501, tm: 12'd1,    exp_temp: 9'd500, exp_tm: 12'd1};
        vecs[5] = '{temp: 9'd500, tm: 12'd0,    exp_temp: 9'd500, exp_tm: 12'd0};
        vecs[6] = '{temp: 9'd350, tm: 12'd3,    exp_temp: 9'd350, exp_tm: 12'd3};
        vecs[7] = '{temp: 9'd0,   tm: 12'd7,    exp_temp: 9'd150, exp_tm: 12'd7};

        // Reset state
        repeat (3) do_cycle();
        check("rst heat_en", heat_en, 0);
        check("rst setpoint", setpoint, 0);
        check("rst remaining", remaining, 0);
        check("rst step_idx", step_idx, 0);
        check("rst busy", busy, 0);
        check("rst step_done", step_done, 0);
        check("rst alarm", alarm, 0);
        rst_n = 1'b1;
        do_cycle();

        // Clamp vectors through entry 0
        for (int i = 0; i < 8; i++) begin
            write_step(2'd0, vecs[i].temp, vecs[i].tm);
            num_steps = 3'd1;
            pulse_start();
            do_cycle();
            check($sformatf("vec%0d setpoint", i), setpoint, vecs[i].exp_temp);
            check($sformatf("vec%0d remaining", i), remaining, vecs[i].exp_tm);
            check($sformatf("vec%0d heat_en", i), heat_en, 1);
            do_abort();
            check($sformatf("vec%0d abort busy", i), busy, 0);
        end

        // Two-step program
        write_step(2'd0, 9'd350, 12'd3);
        write_step(2'd1, 9'd400, 12'd2);
        num_steps = 3'd2;
        d0 = done_cnt;
        pulse_start();
        check("p LOAD busy", busy, 1);
        check("p LOAD idx", step_idx, 0);
        do_cycle();
        check("p s0 setpoint", setpoint, 350);
        check("p s0 remaining", remaining, 3);
        tick();
        repeat (2) do_cycle();
        check("p HEAT ignores tick", remaining, 3);
        oven_ready = 1'b1;
        do_cycle();
        check("p COOK entry remaining", remaining, 3);
        tick();
        check("p s0 rem 2", remaining, 2);
        tick();
        check("p s0 rem 1", remaining, 1);
        tick();
        check("p s0 rem 0", remaining, 0);
        check("p s0 step_done", step_done, 1);
        oven_ready = 1'b0;
        do_cycle();
        check("p s1 idx", step_idx, 1);
        check("p s1 step_done low", step_done, 0);
        do_cycle();
        check("p s1 setpoint", setpoint, 400);
        check("p s1 remaining", remaining, 2);
        repeat (3) do_cycle();
        oven_ready = 1'b1;
        do_cycle();
        tick();
        check("p s1 rem 1", remaining, 1);
        tick();
        check("p s1 rem 0", remaining, 0);
        check("p s1 step_done", step_done, 1);
        do_cycle();
        check("p alarm on", alarm, 1);
        check("p alarm busy", busy, 0);
        check("p alarm heat_en", heat_en, 0);
        check("p done pulses", done_cnt - d0, 2);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("p alarm tick%0d", i), alarm, (i < 10) ? 1 : 0);
        end
        check("p end busy", busy, 0);

        // Ready drop freezes the countdown
        oven_ready = 1'b0;
        write_step(2'd0, 9'd300, 12'd4);
        num_steps = 3'd1;
        pulse_start();
        do_cycle();
        oven_ready = 1'b1;
        do_cycle();
        tick();
        tick();
        check("rd rem 2", remaining, 2);
        oven_ready = 1'b0;
        do_cycle();
        for (int i = 0; i < 5; i++) tick();
        check("rd frozen", remaining, 2);
        check("rd heat_en", heat_en, 1);
        check("rd busy", busy, 1);
        oven_ready = 1'b1;
        do_cycle();
        check("rd resume entry", remaining, 2);
        tick();
        check("rd resume 1", remaining, 1);
        tick();
        check("rd step_done", step_done, 1);
        do_cycle();
        alarm_ack = 1'b1;
        do_cycle();
        alarm_ack = 1'b0;
        check("rd ack alarm", alarm, 0);

        // Zero-time step, then restart straight out of ALARM
        oven_ready = 1'b0;
        write_step(2'd0, 9'd200, 12'd0);
        pulse_start();
        do_cycle();
        oven_ready = 1'b1;
        do_cycle();
        check("z COOK entry no done", step_done, 0);
        do_cycle();
        check("z step_done", step_done, 1);
        do_cycle();
        check("z alarm", alarm, 1);
        pulse_start();
        check("z restart alarm", alarm, 0);
        check("z restart busy", busy, 1);
        check("z restart idx", step_idx, 0);
        do_abort();

        // Abort with coincident tick/start, write while busy ignored
        oven_ready = 1'b0;
        write_step(2'd0, 9'd350, 12'd5);
        pulse_start();
        do_cycle();
        oven_ready = 1'b1;
        do_cycle();
        tick();
        check("ab rem 4", remaining, 4);
        write_step(2'd0, 9'd450, 12'd9);
        d0 = done_cnt;
        abort = 1'b1;
        sec_tick = 1'b1;
        start = 1'b1;
        do_cycle();
        abort = 1'b0;
        sec_tick = 1'b0;
        start = 1'b0;
        check("ab heat_en", heat_en, 0);
        check("ab remaining", remaining, 0);
        check("ab busy", busy, 0);
        check("ab alarm", alarm, 0);
        do_cycle();
        check("ab no step_done", done_cnt - d0, 0);
        check("ab stays idle", busy, 0);
        oven_ready = 1'b0;
        pulse_start();
        do_cycle();
        check("ab table temp kept", setpoint, 350);
        check("ab table time kept", remaining, 5);

        // Asynchronous reset mid-COOK
        oven_ready = 1'b1;
        do_cycle();
        tick();
        check("ar pre rem", remaining, 4);
        #2 rst_n = 1'b0;
        #1;
        check("ar heat_en", heat_en, 0);
        check("ar setpoint", setpoint, 0);
        check("ar remaining", remaining, 0);
        check("ar busy", busy, 0);
        check("ar step_idx", step_idx, 0);
        do_cycle();
        rst_n = 1'b1;
        oven_ready = 1'b0;
        do_cycle();
        pulse_start();
        do_cycle();
        check("ar table temp", setpoint, 150);
        check("ar table time", remaining, 0);
        do_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
